if1_loader: RTL
===============

IF1_LOADER -- requirements
Module: if1_loader

Interface
REQ-001 Parameter: NPIX, default 1024, pixels per frame (32x32 input image); SHALL be a multiple of 4.
REQ-002 Parameter: ADDR_STEP, default 4, BRAM byte-address increment per 32-bit word.
REQ-003 Port: clk  in  1  single clock; all logic rising-edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: s_valid in 1, s_ready out 1, s_data in 8, s_last in 1 — pixel stream; a beat transfers when s_valid&&s_ready.
REQ-006 Ports: mode_in in 1 (1=number, 0=letter); cnn_mode out 1; cnn_start out 1; cnn_done in 1; cnn_result in 8.
REQ-007 Ports: BRAM_IF1_ADDR out 32, BRAM_IF1_WE out 4, BRAM_IF1_EN out 1, BRAM_IF1_DIN out 32 — write port of input-feature BRAM.
REQ-008 Ports: res_valid out 1, res_data out 8, res_ack in 1, busy out 1, err_len out 1.

Function
REQ-009 FSM states SHALL be IDLE, LOAD, FLUSH, START, RUN, HOLD.
REQ-010 IDLE: s_ready=1; first accepted beat latches mode_in into cnn_mode, is packed, and moves to LOAD.
REQ-011 LOAD: s_ready=1; byte k of each word goes to DIN[8k+7:8k] (little-endian, k=0..3).
REQ-012 On acceptance of the 4th byte of word w, next cycle SHALL drive EN=1, WE=4'hF, ADDR=w*ADDR_STEP, DIN=packed word, for exactly one cycle; EN=0, WE=0 otherwise.
REQ-013 Pixel count reaching NPIX SHALL end the frame (-> FLUSH); err_len=1 if s_last was not set on that beat.
REQ-014 s_last on beat n<NPIX-1 SHALL set err_len=1, zero-pad and write any partial word, then return to IDLE without cnn_start.
REQ-015 FLUSH: s_ready=0; waits for the last word write to complete, then -> START.
REQ-016 START: cnn_start=1 for exactly one cycle, -> RUN; cnn_start SHALL follow the last BRAM write by exactly one cycle.
REQ-017 RUN: s_ready=0; on cnn_done=1 capture cnn_result into res_data, set res_valid=1, -> HOLD.
REQ-018 HOLD: res_valid stays 1 and res_data stable until res_ack=1; res_ack SHALL clear res_valid next cycle and return to IDLE.
REQ-019 res_ack while res_valid=0 SHALL be ignored; cnn_done outside RUN SHALL be ignored.
REQ-020 busy=1 in every state except IDLE; s_ready=0 in FLUSH, START, RUN, HOLD.
REQ-021 err_len is sticky; cleared only by rst or by the first beat of the next frame.
REQ-022 Word counter and address SHALL restart at 0 for each frame; no wrap beyond (NPIX/4-1)*ADDR_STEP.

Reset
REQ-023 rst SHALL force IDLE and drive s_ready=0 during the reset cycle, then 1 in IDLE.
REQ-024 Reset values: cnn_start=0, cnn_mode=0, EN=0, WE=0, ADDR=0, DIN=0, res_valid=0, res_data=0, busy=0, err_len=0.
REQ-025 rst mid-LOAD SHALL abandon the frame; no pending partial-word write SHALL issue after reset.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding, NPIX default, ADDR_STEP default and the mode constants (NUMBER=1, LETTER=0).
REQ-027 One sub-module, byte_packer (8-bit beats -> 32-bit word with byte index and word-valid pulse), is natural; the FSM stays in if1_loader.

Verification
REQ-028 Full frame: 1024 bytes, byte i = i mod 256, s_last on last, mode_in=1 -> 256 writes, word 0 DIN=0x03020100 @ADDR 0, word 255 @ADDR 0x3FC, cnn_mode=1, one cnn_start pulse one cycle after last write, err_len=0.
REQ-029 Backpressure/gaps: random s_valid gaps -> identical BRAM contents to REQ-028; no write issued without a completed word.
REQ-030 Short frame: s_last on byte 5 -> words 0x..,(bytes 4,5,0,0) written at ADDR 0 and 4, err_len=1, no cnn_start, back in IDLE.
REQ-031 Result: cnn_done with cnn_result=7 -> res_valid=1, res_data=7 held 10 cycles without ack, cleared the cycle after res_ack; next frame accepted.
REQ-032 Reset mid-LOAD after 6 bytes -> all outputs at reset values next cycle, no further BRAM writes; new full frame then completes normally.
REQ-033 Missing s_last: 1024 bytes, no s_last -> frame still runs, cnn_start issued, err_len=1.

Source files
------------

// File: rtl/if1_loader_pkg.sv
// Shared constants and FSM encoding for the IF1 input-feature loader.
package if1_loader_pkg;

  localparam int NPIX_DEFAULT      = 1024;
  localparam int ADDR_STEP_DEFAULT = 4;

  localparam logic MODE_NUMBER = 1'b1;
  localparam logic MODE_LETTER = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/if1_loader_byte_packer.sv
// Packs accepted 8-bit beats little-endian into 32-bit words and emits a
// registered one-cycle write (word, byte address) per completed or flushed word.
module if1_loader_byte_packer
  import if1_loader_pkg::*;
#(
  parameter int NPIX      = NPIX_DEFAULT,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_beat,
  input  logic        i_sof,
  input  logic        i_flush,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [31:0] o_addr
);

  localparam int NWORDS = NPIX / 4;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [1:0]     r_idx;
  logic [WCW-1:0] r_wcnt;
  logic [31:0]    r_acc;
  logic [31:0]    r_word;
  logic [31:0]    r_addr;
  logic           r_valid;

  logic [1:0]     w_idx;
  logic [WCW-1:0] w_wcnt;
  logic [31:0]    w_acc;
  logic           w_emit;

  // The first beat of a frame restarts both byte lane and word counter.
  always_comb begin
    w_idx  = i_sof ? 2'd0 : r_idx;
    w_wcnt = i_sof ? '0 : r_wcnt;
    w_emit = i_beat && ((w_idx == 2'd3) || i_flush);
  end

  // Lanes above the current byte read as zero, which pads a flushed partial word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_acc[8*gi +: 8] = (w_idx == 2'(gi)) ? i_data :
                              (2'(gi) > w_idx)  ? 8'h00  : r_acc[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_wcnt  <= '0;
      r_acc   <= 32'h0;
      r_word  <= 32'h0;
      r_addr  <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (i_beat) begin
        r_acc <= w_acc;
        r_idx <= i_flush ? 2'd0 : w_idx + 2'd1;
        if (w_emit) begin
          r_word <= w_acc;
          r_addr <= 32'(w_wcnt) * 32'(ADDR_STEP);
          r_wcnt <= i_flush ? '0 : w_wcnt + 1'b1;
        end else begin
          r_wcnt <= w_wcnt;
        end
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;
  assign o_addr       = r_addr;

endmodule

// File: rtl/if1_loader.sv
// Streams one image frame into the IF1 BRAM, kicks the CNN, and holds its
// result until the consumer acknowledges it.
module if1_loader
  import if1_loader_pkg::*;
#(
  parameter int NPIX      = NPIX_DEFAULT,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        mode_in,
  output logic        cnn_mode,
  output logic        cnn_start,
  input  logic        cnn_done,
  input  logic [7:0]  cnn_result,
  output logic [31:0] BRAM_IF1_ADDR,
  output logic [3:0]  BRAM_IF1_WE,
  output logic        BRAM_IF1_EN,
  output logic [31:0] BRAM_IF1_DIN,
  output logic        res_valid,
  output logic [7:0]  res_data,
  input  logic        res_ack,
  output logic        busy,
  output logic        err_len
);

  localparam int PCW = $clog2(NPIX + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [PCW-1:0] r_pix_cnt;
  logic           r_mode;
  logic           r_err_len;
  logic           r_res_valid;
  logic [7:0]     r_res_data;

  logic           w_ready;
  logic           w_beat;
  logic           w_sof;
  logic           w_frame_end;
  logic           w_short_end;
  logic           w_flush;
  logic           w_word_valid;
  logic [31:0]    w_word;
  logic [31:0]    w_addr;

  assign w_beat      = s_valid && w_ready;
  assign w_sof       = w_beat && (r_state == S_IDLE);
  assign w_frame_end = w_beat && !w_sof && (r_pix_cnt == PCW'(NPIX - 1));
  assign w_short_end = w_beat && s_last && !w_frame_end;
  assign w_flush     = w_frame_end || w_short_end;

  if1_loader_byte_packer #(
    .NPIX      (NPIX),
    .ADDR_STEP (ADDR_STEP)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_beat       (w_beat),
    .i_sof        (w_sof),
    .i_flush      (w_flush),
    .i_data       (s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_addr       (w_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    cnn_start    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ready = !rst;
        busy    = 1'b0;
        if (w_sof && !w_short_end) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_ready = !rst;
        if (w_frame_end)      w_state_next = S_FLUSH;
        else if (w_short_end) w_state_next = S_IDLE;
      end
      // The final word write is in flight this cycle; start follows it.
      S_FLUSH: if (w_word_valid) w_state_next = S_START;
      S_START: begin
        cnn_start    = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN:   if (cnn_done) w_state_next = S_HOLD;
      S_HOLD:  if (res_ack)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt   <= '0;
      r_mode      <= MODE_LETTER;
      r_err_len   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
    end else begin
      if (w_beat) r_pix_cnt <= w_sof ? PCW'(1) : r_pix_cnt + 1'b1;
      if (w_sof)  r_mode <= (mode_in == MODE_NUMBER) ? MODE_NUMBER : MODE_LETTER;
      // A length error on the first beat must win over the start-of-frame clear.
      if (w_short_end || (w_frame_end && !s_last)) r_err_len <= 1'b1;
      else if (w_sof)                               r_err_len <= 1'b0;
      if (r_state == S_RUN && cnn_done) begin
        r_res_valid <= 1'b1;
        r_res_data  <= cnn_result;
      end else if (r_state == S_HOLD && res_ack) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign s_ready       = w_ready;
  assign cnn_mode      = r_mode;
  assign err_len       = r_err_len;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign BRAM_IF1_EN   = w_word_valid;
  assign BRAM_IF1_WE   = {4{w_word_valid}};
  assign BRAM_IF1_ADDR = w_addr;
  assign BRAM_IF1_DIN  = w_word;

endmodule
